// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_arbiter
// Purpose  : Single-port framebuffer RAM arbiter. Display scan-out reads take
//            fixed priority over PPU writes. Writes are buffered in a small
//            FIFO and drained in acceptance order whenever no read is
//            requested. Reads have a fixed 3-cycle latency from request to
//            rd_valid and sustain one pixel per cycle.
//
// Ports    : clk, rst          - clock (rising edge), async active-high reset
//            rd_req/rd_addr    - scan-out read request and address
//            rd_valid/rd_data  - registered read result
//            wr_req/wr_addr/wr_data/wr_ready - PPU write buffer push side
//            mem_en/mem_we/mem_addr/mem_wdata - registered RAM command
//            mem_rdata         - RAM read data, valid one cycle after a read
//            stall_count       - count of cycles a write was refused
//
// Options  : FB_ARB_STATS_EN  - when defined, stall_count is a saturating
//                               counter; otherwise it is tied to zero.
//
// Revision : 1.0 - initial release
// ============================================================================
module fb_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  // --------------------------------------------------------------------------
  // Write buffer state
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic push;
  logic pop;

  // Pointers wrap explicitly at FIFO_DEPTH-1 so the wrap point does not rely
  // on the natural roll-over of the pointer width.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Ready depends only on the registered occupancy: a pop in the same cycle
  // never makes room visible before the next cycle.
  assign wr_ready = (count_q < DEPTH_C);
  assign push     = wr_req & wr_ready;
  // Pop decisions also use the registered occupancy, so a freshly pushed
  // entry cannot be issued in the cycle it arrives (no bypass path).
  assign pop      = ~rd_req & (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Buffer storage needs no reset: occupancy gates every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= wr_addr;
      fifo_data_q[wptr_q] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // RAM command register and read return pipeline
  //   cycle N   : arbitration decision
  //   cycle N+1 : command on mem_* (rd_issue_q marks a read)
  //   cycle N+2 : mem_rdata valid (rd_wait_q)
  //   cycle N+3 : rd_valid / rd_data
  // --------------------------------------------------------------------------
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd_issue_q;
  logic              rd_wait_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_issue_q  <= 1'b0;
      rd_wait_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      if (rd_req) begin
        mem_en_q   <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= rd_addr;
      end else if (pop) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= fifo_addr_q[rptr_q];
        mem_wdata_q <= fifo_data_q[rptr_q];
      end else begin
        // Idle: address and write data hold their last values.
        mem_en_q <= 1'b0;
        mem_we_q <= 1'b0;
      end

      rd_issue_q <= rd_req;
      rd_wait_q  <= rd_issue_q;
      rd_valid_q <= rd_wait_q;
      if (rd_wait_q) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  // --------------------------------------------------------------------------
  // Write-stall statistic
  // --------------------------------------------------------------------------
`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (wr_req && !wr_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_arbiter
// Purpose  : Self-checking bench for fb_arbiter. A queue-based reference
//            model tracks pending writes, a golden memory image and the
//            expected cycle of every read return. Directed scenarios are
//            followed by a randomized phase.
// Options  : FB_ARB_STATS_EN - selects the expected stall_count behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [15:0]       stall_count;

  fb_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one cycle of read latency.
  logic [DATA_W-1:0] ram [MEM_N];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Reference model state
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] golden [MEM_N];
  logic [ADDR_W-1:0] q_a [$];
  logic [DATA_W-1:0] q_d [$];
  int                rv_cyc [$];
  logic [DATA_W-1:0] rv_dat [$];
  logic              e_en, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_a;
  logic [DATA_W-1:0] pend_d;
  int                e_stall;
  int                cyc;
  int                n_pass = 0;
  int                n_total = 0;
  int                n_fail = 0;

`ifdef FB_ARB_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic exp_v;
    int   exp_stall;
    exp_stall = (STATS_ON != 0) ? e_stall : 0;
    chk("wr_ready", 32'(wr_ready), 32'(q_a.size() < DEPTH));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    exp_v = (rv_cyc.size() > 0) && (rv_cyc[0] == cyc);
    chk("rd_valid", 32'(rd_valid), 32'(exp_v));
    if (exp_v) begin
      chk("rd_data", 32'(rd_data), 32'(rv_dat[0]));
      void'(rv_cyc.pop_front());
      void'(rv_dat.pop_front());
    end
    chk("stall_count", 32'(stall_count), 32'(exp_stall));
  endtask

  // One arbitration cycle, entered and left at a falling edge.
  task automatic cycle(input logic rd, input logic [ADDR_W-1:0] ra,
                       input logic wr, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd);
    logic ready;
    check_outputs();
    rd_req = rd; rd_addr = ra; wr_req = wr; wr_addr = wa; wr_data = wd;
    ready = (q_a.size() < DEPTH);
    // The write issued last cycle lands in RAM at the end of this cycle,
    // ahead of any read decided now.
    if (pend_v) begin
      golden[pend_a] = pend_d;
      pend_v = 1'b0;
    end
    if (wr && !ready && e_stall != 32'hFFFF) e_stall++;
    if (rd) begin
      e_en = 1'b1; e_we = 1'b0; e_addr = ra;
      rv_cyc.push_back(cyc + 3);
      rv_dat.push_back(golden[ra]);
    end else if (q_a.size() > 0) begin
      e_en = 1'b1; e_we = 1'b1;
      e_addr = q_a.pop_front();
      e_wdata = q_d.pop_front();
      pend_v = 1'b1; pend_a = e_addr; pend_d = e_wdata;
    end else begin
      e_en = 1'b0; e_we = 1'b0;
    end
    if (wr && ready) begin
      q_a.push_back(wa);
      q_d.push_back(wd);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    rd_req = 1'b0; wr_req = 1'b0;
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_a.delete(); q_d.delete(); rv_cyc.delete(); rv_dat.delete();
    pend_v = 1'b0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_stall = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] v;
    cyc = 0;
    for (int i = 0; i < MEM_N; i++) begin
      v = DATA_W'($urandom);
      ram[i] = v;
      golden[i] = v;
    end
    ram[16'h0010] = 8'hA5; golden[16'h0010] = 8'hA5;
    ram[16'h0100] = 8'h3C; golden[16'h0100] = 8'h3C;

    @(negedge clk);
    do_reset(2);
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

    // Single read of a known word.
    cycle(1'b1, 15'h0010, 1'b0, '0, '0);
    idle(4);

    // Two writes drain in order on consecutive cycles.
    cycle(1'b0, '0, 1'b1, 15'h0001, 8'h11);
    cycle(1'b0, '0, 1'b1, 15'h0002, 8'h22);
    idle(4);

    // Reads held for 10 cycles while 5 writes are offered.
    for (int i = 0; i < 10; i++)
      cycle(1'b1, ADDR_W'(16'h0040 + i), (i < 5), ADDR_W'(16'h0020 + i), DATA_W'(8'h30 + i));
    idle(8);
    chk("stall_after_10rd", 32'(stall_count), 32'(STATS_ON));

    // Full FIFO, no read, write offered: pop happens, ready rises next cycle.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, ADDR_W'(16'h0060 + i), 1'b1, ADDR_W'(16'h0070 + i), DATA_W'(8'h70 + i));
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    cycle(1'b0, '0, 1'b1, 15'h0080, 8'h80);
    chk("after_pop_wr_ready", 32'(wr_ready), 32'd1);
    cycle(1'b0, '0, 1'b1, 15'h0080, 8'h80);
    idle(8);

    // Reset with buffered writes and reads in flight.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, ADDR_W'(16'h0090 + i), 1'b1, ADDR_W'(16'h00A0 + i), DATA_W'(8'hA0 + i));
    do_reset(1);
    chk("rst_mid_wr_ready", 32'(wr_ready), 32'd1);
    idle(6);

    // Pending write not forwarded to a read of the same address.
    cycle(1'b1, 15'h0050, 1'b1, 15'h0100, 8'h5A);
    cycle(1'b1, 15'h0100, 1'b0, '0, '0);
    idle(4);
    cycle(1'b1, 15'h0100, 1'b0, '0, '0);
    idle(4);

    // Randomized traffic over a small address window to provoke hazards.
    for (int i = 0; i < 500; i++)
      cycle(($urandom_range(0, 99) < 45), ADDR_W'($urandom_range(0, 63)),
            ($urandom_range(0, 99) < 65), ADDR_W'($urandom_range(0, 63)),
            DATA_W'($urandom));
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 15, framebuffer address width (160x144 pixels).
REQ-002 SHALL have parameter DATA_W, 8, pixel word width.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, write-buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  in  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rd_req  in  1  display scan-out read request, one pixel per cycle.
REQ-007 SHALL have port rd_addr  in  ADDR_W  read address, sampled with rd_req.
REQ-008 SHALL have port rd_valid  out  1  rd_data holds the result of a read.
REQ-009 SHALL have port rd_data  out  DATA_W  read result.
REQ-010 SHALL have port wr_req  in  1  PPU write request.
REQ-011 SHALL have port wr_addr  in  ADDR_W  write address.
REQ-012 SHALL have port wr_data  in  DATA_W  write data.
REQ-013 SHALL have port wr_ready  out  1  write buffer can accept an entry.
REQ-014 SHALL have port mem_en  out  1  single-port RAM enable.
REQ-015 SHALL have port mem_we  out  1  RAM write enable.
REQ-016 SHALL have port mem_addr  out  ADDR_W  RAM address.
REQ-017 SHALL have port mem_wdata  out  DATA_W  RAM write data.
REQ-018 SHALL have port mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read is issued.
REQ-019 SHALL have port stall_count  out  16  write-stall statistic (see Configuration).

Function
REQ-020 SHALL accept a write when wr_req && wr_ready in the same cycle, pushing {wr_addr, wr_data} into the FIFO.
REQ-021 SHALL drive wr_ready = (registered occupancy < FIFO_DEPTH); a pop in the same cycle does not raise wr_ready while full.
REQ-022 SHALL register all mem_* outputs; the RAM operation is issued the cycle after the arbitration decision.
REQ-023 SHALL arbitrate each cycle with fixed priority: rd_req first; else FIFO non-empty issues the head write (mem_we=1) and pops; else idle (mem_en=0, mem_we=0).
REQ-024 SHALL, on a read decision in cycle N, drive mem_en=1, mem_we=0, mem_addr=rd_addr in N+1, and rd_valid=1 with rd_data=mem_rdata (registered) in N+3; fixed read latency is 3 cycles.
REQ-025 SHALL sustain back-to-back reads at one per cycle with no bubbles.
REQ-026 SHALL hold mem_addr and mem_wdata at their last values when idle.
REQ-027 SHALL drain writes in acceptance order.
REQ-028 SHALL NOT forward pending FIFO data to reads; a read of an address with a pending write returns RAM contents.
REQ-029 SHALL allow simultaneous push and pop when occupancy is between 1 and FIFO_DEPTH-1, leaving occupancy unchanged.
REQ-030 SHALL, with occupancy 0 and a push plus no rd_req, issue that write no earlier than the next arbitration cycle (no FIFO bypass).
REQ-031 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-032 SHALL on rst clear FIFO occupancy and pointers, drive rd_valid=0, rd_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, stall_count=0, and drive wr_ready=1 once rst deasserts.
REQ-033 SHALL discard in-flight reads and buffered writes when rst asserts mid-operation; no rd_valid follows a pre-reset read.

Configuration
REQ-034 SHALL, with FB_ARB_STATS_EN defined, increment stall_count each cycle wr_req && !wr_ready, saturating at 16'hFFFF.
REQ-035 SHALL, with FB_ARB_STATS_EN undefined, tie stall_count to 16'h0000 and contain no counter logic.

Verification
REQ-036 SHALL cover: reset, then rd_req=1 with rd_addr=0x0010 for one cycle and RAM word 0x0010=0xA5 -> mem_en=1/mem_we=0/mem_addr=0x0010 one cycle later, rd_valid=1 with rd_data=0xA5 three cycles after request.
REQ-037 SHALL cover: with rd_req=0, push writes (0x0001,0x11),(0x0002,0x22) -> mem_we=1 to 0x0001 then 0x0002 on consecutive cycles, in order.
REQ-038 SHALL cover: rd_req held high 10 cycles while 5 writes are offered -> 4 accepted, wr_ready=0 on 5th, no mem_we during reads, 4 writes drain right after rd_req drops; stall_count=1 with FB_ARB_STATS_EN, 0 without.
REQ-039 SHALL cover: FIFO full with rd_req=0 and wr_req=1 -> pop occurs, wr_ready stays 0 that cycle, rises next cycle.
REQ-040 SHALL cover: rst asserted with 3 buffered writes and 2 reads in flight -> no mem_we and no rd_valid after reset, wr_ready=1.
REQ-041 SHALL cover: write (0x0100,0x5A) pending while read of 0x0100 issued -> rd_data equals old RAM value, later read returns 0x5A.
